// File: rtl/ex2_pkg.sv
// Shared definitions for the MAC triple feeder.
// Holds the default stream width, the triple-counter width, the feeder
// FSM state encoding and the default-width operand triple record.
package ex2_pkg;

    localparam int DEF_W = 32;   // default operand / stream word width
    localparam int CNT_W = 16;   // width of the completed-triple counter

    typedef enum logic [2:0] {
        IDLE,
        SEND_A,
        SEND_B,
        SEND_C,
        GAP_WAIT
    } feeder_state_t;

    // Operand triple at the default width; a is the most significant field.
    typedef struct packed {
        logic [DEF_W-1:0] a;
        logic [DEF_W-1:0] b;
        logic [DEF_W-1:0] c;
    } triple_t;

endpackage

// File: rtl/triple_fifo.sv
// Synchronous FIFO holding whole operand triples.
// Ports:
//   clk, rst_n   clock and synchronous active-low reset (empties the FIFO)
//   push, din    write one entry (ignored while full)
//   pop, dout    dout shows the head entry; pop removes it (ignored while empty)
//   full, empty  status derived from the registered pointers only
//   level        number of entries currently stored (0..DEPTH)
module triple_fifo #(
    parameter int DATA_W = 96,
    parameter int DEPTH  = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    push,
    input  logic                    pop,
    input  logic [DATA_W-1:0]       din,
    output logic [DATA_W-1:0]       dout,
    output logic                    full,
    output logic                    empty,
    output logic [$clog2(DEPTH):0]  level
);
    localparam int AW = $clog2(DEPTH);

    // Pointers carry one extra bit so full and empty are distinguishable
    // when the address bits coincide.
    logic [AW:0]        wr_ptr_q, wr_ptr_d;
    logic [AW:0]        rd_ptr_q, rd_ptr_d;
    logic [DATA_W-1:0]  mem_q [DEPTH];
    logic               do_push, do_pop;

    assign level = wr_ptr_q - rd_ptr_q;
    assign full  = (level == (AW+1)'(DEPTH));
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign dout  = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        do_push  = push && !full;
        do_pop   = pop && !empty;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + (AW+1)'(1);
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // NOTE: storage is not reset; an entry is only read after it has been written.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= din;
    end

endmodule

// File: rtl/mac_triple_feeder.sv
// Upstream stage of the a*b+c MAC sequencer.
// Buffers operand triples and serialises each one onto the MAC word stream
// as three consecutive valid words a, b, c, optionally followed by GAP idle
// cycles. hold pauses emission only at triple boundaries, so the MAC never
// sees a partial triple except across a reset.
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   in_valid/in_ready   producer handshake; a triple is pushed when both are 1
//   in_a, in_b, in_c    operand triple
//   hold                pause emission at the next triple boundary
//   validi, data_out    registered stream word to the MAC (data_out=0 when idle)
//   level               triples currently buffered
//   triple_cnt          completed triples emitted (wraps at 16 bits)
module mac_triple_feeder
    import ex2_pkg::*;
#(
    parameter int W     = DEF_W,
    parameter int DEPTH = 4,
    parameter int GAP   = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [W-1:0]            in_a,
    input  logic [W-1:0]            in_b,
    input  logic [W-1:0]            in_c,
    input  logic                    hold,
    output logic                    validi,
    output logic [W-1:0]            data_out,
    output logic [$clog2(DEPTH):0]  level,
    output logic [CNT_W-1:0]        triple_cnt
);
    localparam int GAP_CW = (GAP > 1) ? $clog2(GAP) : 1;

    typedef struct packed {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] c;
    } slot_t;

    feeder_state_t      state_q, state_d;
    slot_t              hold_reg_q, hold_reg_d;
    logic [GAP_CW-1:0]  gap_cnt_q, gap_cnt_d;
    logic [CNT_W-1:0]   triple_cnt_q, triple_cnt_d;
    logic               validi_q, validi_d;
    logic [W-1:0]       data_out_q, data_out_d;

    slot_t              fifo_din, fifo_dout;
    logic               fifo_push, fifo_pop, fifo_full, fifo_empty;

    assign fifo_din  = {in_a, in_b, in_c};
    // in_ready depends only on registered FIFO state: a full FIFO refuses a
    // push even in a cycle where the FSM pops.
    assign in_ready  = !fifo_full;
    assign fifo_push = in_valid && in_ready;

    triple_fifo #(
        .DATA_W (3*W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (fifo_din),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (level)
    );

    always_comb begin
        state_d      = state_q;
        hold_reg_d   = hold_reg_q;
        gap_cnt_d    = gap_cnt_q;
        triple_cnt_d = triple_cnt_q;
        fifo_pop     = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (!fifo_empty && !hold) begin
                    fifo_pop   = 1'b1;
                    hold_reg_d = fifo_dout;
                    state_d    = SEND_A;
                end
            end
            SEND_A: state_d = SEND_B;
            SEND_B: state_d = SEND_C;
            SEND_C: begin
                triple_cnt_d = triple_cnt_q + CNT_W'(1);
                if (GAP > 0) begin
                    state_d   = GAP_WAIT;
                    gap_cnt_d = GAP_CW'((GAP > 0) ? GAP - 1 : 0);
                end else if (!fifo_empty && !hold) begin
                    fifo_pop   = 1'b1;
                    hold_reg_d = fifo_dout;
                    state_d    = SEND_A;
                end else begin
                    state_d = IDLE;
                end
            end
            GAP_WAIT: begin
                if (gap_cnt_q == '0) state_d = IDLE;
                else                 gap_cnt_d = gap_cnt_q - GAP_CW'(1);
            end
            default: state_d = IDLE;
        endcase

        // Outputs are decoded from the next state and registered, so the
        // word for a state appears in the same cycle the state is entered.
        // hold_reg_d already holds a freshly popped triple on entry to SEND_A.
        validi_d   = 1'b0;
        data_out_d = '0;
        unique case (state_d)
            SEND_A: begin validi_d = 1'b1; data_out_d = hold_reg_d.a; end
            SEND_B: begin validi_d = 1'b1; data_out_d = hold_reg_d.b; end
            SEND_C: begin validi_d = 1'b1; data_out_d = hold_reg_d.c; end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            hold_reg_q   <= '0;
            gap_cnt_q    <= '0;
            triple_cnt_q <= '0;
            validi_q     <= 1'b0;
            data_out_q   <= '0;
        end else begin
            state_q      <= state_d;
            hold_reg_q   <= hold_reg_d;
            gap_cnt_q    <= gap_cnt_d;
            triple_cnt_q <= triple_cnt_d;
            validi_q     <= validi_d;
            data_out_q   <= data_out_d;
        end
    end

    assign validi     = validi_q;
    assign data_out   = data_out_q;
    assign triple_cnt = triple_cnt_q;

endmodule

// File: tb/tb_mac_triple_feeder.sv
module tb_mac_triple_feeder;
    import ex2_pkg::*;

    localparam int W     = DEF_W;
    localparam int DEPTH = 4;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             hold = 1'b0;
    logic [W-1:0]     in_a = '0, in_b = '0, in_c = '0;

    // GAP=1 instance (scoreboarded) and GAP=0 instance (back-to-back stream)
    logic             in_ready, validi;
    logic [W-1:0]     data_out;
    logic [LW-1:0]    level;
    logic [CNT_W-1:0] triple_cnt;
    logic             in_ready0, validi0;
    logic [W-1:0]     data_out0;
    logic [LW-1:0]    level0;
    logic [CNT_W-1:0] triple_cnt0;

    mac_triple_feeder #(.W(W), .DEPTH(DEPTH), .GAP(1)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_c(in_c), .hold(hold),
        .validi(validi), .data_out(data_out), .level(level), .triple_cnt(triple_cnt)
    );

    mac_triple_feeder #(.W(W), .DEPTH(DEPTH), .GAP(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0),
        .in_a(in_a), .in_b(in_b), .in_c(in_c), .hold(hold),
        .validi(validi0), .data_out(data_out0), .level(level0), .triple_cnt(triple_cnt0)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    logic [W-1:0] exp_q[$];
    bit mon_en = 1'b0;

    typedef logic [0:2][W-1:0] words_t;

    typedef struct {
        triple_t          t;
        words_t           exp_words;
        logic [CNT_W-1:0] exp_cnt;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic words_t words_of(input triple_t t);
        return {t.a, t.b, t.c};
    endfunction

    // Scoreboard: each valid word of the GAP=1 instance must be the next
    // expected word; idle cycles must show data_out=0.
    always @(negedge clk) begin
        if (mon_en) begin
            if (validi === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL stream_unexpected: got word %0h with nothing expected at %0t", data_out, $time);
                end else begin
                    check("stream_word", data_out, exp_q.pop_front());
                end
            end else begin
                check("idle_data_zero", data_out, 0);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        in_valid = 1'b0;
        hold     = 1'b0;
        tick();
        rst_n = 1'b1;
        exp_q.delete();
    endtask

    // Offers a triple until accepted (bounded); expected words enter the
    // scoreboard in the cycle the push is accepted.
    task automatic push_triple(input triple_t t, input words_t ew);
        bit ok = 1'b0;
        in_a = t.a; in_b = t.b; in_c = t.c;
        in_valid = 1'b1;
        for (int i = 0; i < 60; i++) begin
            if (in_ready) begin
                for (int k = 0; k < 3; k++) exp_q.push_back(ew[k]);
                tick();
                ok = 1'b1;
                break;
            end
            tick();
        end
        in_valid = 1'b0;
        if (!ok) check("push_timeout", 0, 1);
    endtask

    task automatic wait_cnt(input logic [CNT_W-1:0] target, input int budget, input string name);
        int n = 0;
        while (triple_cnt !== target && n < budget) begin
            tick();
            n++;
        end
        check(name, triple_cnt, target);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t      vecs[4];
        triple_t   t1, t2;
        logic [W-1:0] cap_a, cap_b, cap_c;
        logic [8:0] pat1, pat0;
        logic [W-1:0] words0[6];
        int cnt_v;

        vecs[0] = '{t: '{a: 32'hDEADBEEF, b: 32'h1, c: 32'hFFFFFFFF},
                    exp_words: {32'hDEADBEEF, 32'h1, 32'hFFFFFFFF}, exp_cnt: 16'd1};
        vecs[1] = '{t: '{a: 32'h0, b: 32'h0, c: 32'h0},
                    exp_words: {32'h0, 32'h0, 32'h0}, exp_cnt: 16'd2};
        vecs[2] = '{t: '{a: 32'hAAAAAAAA, b: 32'h55555555, c: 32'h12345678},
                    exp_words: {32'hAAAAAAAA, 32'h55555555, 32'h12345678}, exp_cnt: 16'd3};
        vecs[3] = '{t: '{a: 32'h7FFFFFFF, b: 32'h80000000, c: 32'h1},
                    exp_words: {32'h7FFFFFFF, 32'h80000000, 32'h1}, exp_cnt: 16'd4};

        // Reset state
        do_reset();
        mon_en = 1'b1;
        check("rst_validi", validi, 0);
        check("rst_data_out", data_out, 0);
        check("rst_level", level, 0);
        check("rst_triple_cnt", triple_cnt, 0);
        check("rst_in_ready", in_ready, 1);

        // Single triple (2,3,4): a two cycles after the accepting edge
        t1 = '{a: 32'd2, b: 32'd3, c: 32'd4};
        push_triple(t1, words_of(t1));
        check("lat_n1_validi", validi, 0);
        check("lat_n1_level", level, 1);
        tick();
        check("lat_a_validi", validi, 1);
        cap_a = data_out;
        check("lat_a_data", cap_a, 2);
        tick();
        check("lat_b_validi", validi, 1);
        cap_b = data_out;
        check("lat_b_data", cap_b, 3);
        tick();
        check("lat_c_validi", validi, 1);
        cap_c = data_out;
        check("lat_c_data", cap_c, 4);
        tick();
        check("lat_after_validi", validi, 0);
        check("lat_after_data", data_out, 0);
        check("lat_triple_cnt", triple_cnt, 1);
        check("mac_result", cap_a * cap_b + cap_c, 10);

        // Table-driven vectors, one triple at a time
        do_reset();
        for (int i = 0; i < 4; i++) begin
            push_triple(vecs[i].t, vecs[i].exp_words);
            wait_cnt(vecs[i].exp_cnt, 30, "vec_triple_cnt");
            check("vec_level", level, 0);
        end

        // Two triples back-to-back on both GAP instances
        do_reset();
        t1 = '{a: 32'd1, b: 32'd2, c: 32'd3};
        t2 = '{a: 32'd5, b: 32'd6, c: 32'd7};
        push_triple(t1, words_of(t1));
        push_triple(t2, words_of(t2));
        cnt_v = 0;
        for (int i = 0; i < 9; i++) begin
            pat1[8-i] = validi;
            pat0[8-i] = validi0;
            if (validi0 && cnt_v < 6) begin
                words0[cnt_v] = data_out0;
                cnt_v++;
            end
            tick();
        end
        check("b2b_gap1_validi_pattern", pat1, 9'b111001110);
        check("b2b_gap0_validi_pattern", pat0, 9'b111111000);
        check("b2b_gap0_word0", words0[0], 1);
        check("b2b_gap0_word1", words0[1], 2);
        check("b2b_gap0_word2", words0[2], 3);
        check("b2b_gap0_word3", words0[3], 5);
        check("b2b_gap0_word4", words0[4], 6);
        check("b2b_gap0_word5", words0[5], 7);
        check("b2b_gap0_triple_cnt", triple_cnt0, 2);
        check("b2b_gap0_level", level0, 0);
        check("b2b_gap0_in_ready", in_ready0, 1);
        check("b2b_gap1_triple_cnt", triple_cnt, 2);

        // hold=1 with DEPTH+1 triples offered
        do_reset();
        hold = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            t1 = '{a: W'(16 + 3*i), b: W'(17 + 3*i), c: W'(18 + 3*i)};
            push_triple(t1, words_of(t1));
        end
        check("full_level", level, DEPTH);
        check("full_in_ready", in_ready, 0);
        t2 = '{a: 32'h100, b: 32'h101, c: 32'h102};
        in_a = t2.a; in_b = t2.b; in_c = t2.c;
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("hold_no_emit", validi, 0);
        end
        check("full_stays_level", level, DEPTH);
        hold = 1'b0;
        tick();
        check("first_pop_level", level, DEPTH - 1);
        check("first_pop_in_ready", in_ready, 1);
        check("first_pop_validi", validi, 1);
        for (int k = 0; k < 3; k++) exp_q.push_back(words_of(t2)[k]);
        tick();
        in_valid = 1'b0;
        check("fifth_accepted_level", level, DEPTH);
        wait_cnt(16'd5, 100, "hold_release_triple_cnt");
        check("hold_release_level", level, 0);

        // hold raised during SEND_B of (7,8,9)
        do_reset();
        t1 = '{a: 32'd7, b: 32'd8, c: 32'd9};
        t2 = '{a: 32'd10, b: 32'd11, c: 32'd12};
        push_triple(t1, words_of(t1));
        push_triple(t2, words_of(t2));
        tick();
        check("midhold_in_send_b", data_out, 8);
        hold = 1'b1;
        cnt_v = 0;
        for (int i = 0; i < 8; i++) begin
            if (validi) cnt_v++;
            tick();
        end
        check("midhold_valid_words", cnt_v, 2);
        check("midhold_triple_cnt", triple_cnt, 1);
        check("midhold_level", level, 1);
        check("midhold_validi", validi, 0);
        hold = 1'b0;
        wait_cnt(16'd2, 50, "midhold_release_cnt");

        // Reset after a,b of (4,5,6) with two triples queued
        do_reset();
        t1 = '{a: 32'd4, b: 32'd5, c: 32'd6};
        push_triple(t1, words_of(t1));
        t2 = '{a: 32'd1, b: 32'd2, c: 32'd3};
        push_triple(t2, words_of(t2));
        t2 = '{a: 32'd7, b: 32'd7, c: 32'd7};
        push_triple(t2, words_of(t2));
        check("midrst_in_send_b", data_out, 5);
        check("midrst_queued", level, 2);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        exp_q.delete();
        check("midrst_validi", validi, 0);
        check("midrst_data_out", data_out, 0);
        check("midrst_level", level, 0);
        check("midrst_triple_cnt", triple_cnt, 0);
        check("midrst_in_ready", in_ready, 1);
        cnt_v = 0;
        for (int i = 0; i < 10; i++) begin
            if (validi) cnt_v++;
            tick();
        end
        check("midrst_no_words", cnt_v, 0);

        // triple_cnt wrap: preload 0xFFFF, emit one more triple
        do_reset();
        force dut.triple_cnt_q = 16'hFFFF;
        tick();
        release dut.triple_cnt_q;
        tick();
        check("wrap_preload", triple_cnt, 16'hFFFF);
        t1 = '{a: 32'h9, b: 32'h9, c: 32'h9};
        push_triple(t1, words_of(t1));
        wait_cnt(16'h0000, 30, "wrap_triple_cnt");
        tick();
        check("wrap_stays_zero", triple_cnt, 0);

        mon_en = 1'b0;
        check("scoreboard_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mac_triple_feeder.md
Name: mac_triple_feeder

Overview:
- Upstream stage of the a*b+c MAC sequencer.
- Accepts operand triples (a,b,c) from a producer over a valid/ready handshake and buffers them in a small FIFO.
- Serialises each triple onto the MAC's word stream as three consecutive validi cycles: a, then b, then c.
- Guarantees the MAC never sees a partial triple, except on reset.

Parameters:
- W, 32, operand and stream word width
- DEPTH, 4, FIFO capacity in triples (power of 2, >=2)
- GAP, 1, idle cycles forced with validi=0 between triples (0 = back-to-back)

Ports:
- clk  in  1  clock, all logic on posedge
- rst_n  in  1  synchronous active-low reset
- in_valid  in  1  producer offers a triple
- in_ready  out  1  feeder can accept a triple
- in_a  in  W  operand a
- in_b  in  W  operand b
- in_c  in  W  operand c
- hold  in  1  request to pause emission at triple boundaries
- validi  out  1  stream word valid (drives MAC validi)
- data_out  out  W  stream word (drives MAC data_in)
- level  out  $clog2(DEPTH)+1  triples currently buffered
- triple_cnt  out  16  completed triples emitted

Behaviour:
- Reset (rst_n=0 at posedge):
  - FIFO emptied, FSM to IDLE.
  - validi=0, data_out=0, level=0, triple_cnt=0, in_ready=1 from the next cycle.
  - Reset mid-triple discards the partial triple. validi drops, which resynchronises the MAC.
- Input handshake:
  - Push when in_valid && in_ready at posedge.
  - in_ready = !full, registered-state based. There is no same-cycle pop bypass, so a full FIFO refuses a push even when a pop occurs in that cycle.
  - in_valid while in_ready=0 has no effect; the producer holds its data.
- FSM states: IDLE, SEND_A, SEND_B, SEND_C, GAP_WAIT.
- IDLE:
  - If FIFO non-empty and hold=0: pop the head into the holding register and go to SEND_A.
  - Otherwise stay in IDLE.
- SEND_A, SEND_B, SEND_C:
  - Output registered: validi=1, data_out = a, b, c respectively.
  - Unconditional progression A->B->C. hold is ignored inside a triple.
- Leaving SEND_C:
  - triple_cnt increments, wrapping 0xFFFF->0.
  - If GAP>0: go to GAP_WAIT for exactly GAP cycles with validi=0, then IDLE.
  - If GAP=0 and FIFO non-empty and hold=0: pop the next triple and go directly to SEND_A (continuous stream).
  - Otherwise go to IDLE.
- Whenever validi=0, data_out=0 (deterministic, checkable).
- Latency: a push accepted in cycle n with an empty FIFO and FSM in IDLE produces validi=1 with a in cycle n+2, b in n+3, c in n+4.
- Throughput: one triple per 3+GAP cycles, plus one IDLE cycle when GAP>0.
- level: +1 on push, -1 on pop, unchanged on simultaneous push and pop. Never exceeds DEPTH and never goes below 0.
- Operands pass through unmodified. No arithmetic on data; width W throughout.

Decomposition:
- Package ex2_pkg:
  - W default constant
  - feeder_state_t enum {IDLE, SEND_A, SEND_B, SEND_C, GAP_WAIT}
  - packed struct triple_t {a,b,c}
  - CNT_W=16
- Sub-module triple_fifo: synchronous FIFO of triple_t with parameter DEPTH.
  - Ports: push, pop, din, dout, full, empty, level.
  - Pointer wrap on DEPTH, with an extra pointer bit for full/empty.
- Top holds the FSM, the GAP counter, the holding register, the output registers and triple_cnt.

Test Plan:
- Single triple (a=2,b=3,c=4), GAP=1, hold=0:
  - validi=1 in cycles n+2..n+4 with data 2,3,4, then validi=0, data_out=0.
  - triple_cnt=1; a connected MAC reports 10.
- Two triples pushed back-to-back, (1,2,3) and (5,6,7):
  - GAP=0: six consecutive validi cycles 1,2,3,5,6,7.
  - GAP=1: exactly one validi=0 cycle between 3 and 5, plus the IDLE cycle.
- hold=1, push DEPTH+1 triples:
  - First 4 accepted, level=4, in_ready=0 on the fifth; no validi.
  - Release hold: fifth accepted the cycle after the first pop; all 5 triples emitted in order.
- Assert hold during SEND_B of triple (7,8,9):
  - 7,8,9 emitted complete.
  - No new triple starts until hold=0.
- rst_n=0 for one cycle after a,b of (4,5,6) emitted, with 2 triples queued:
  - validi=0, level=0, triple_cnt=0 the next cycle.
  - c=6 and the queued triples are never emitted.
- Preload triple_cnt to 0xFFFF via 65535 triples (or force in bench), emit one more:
  - triple_cnt wraps to 0.
